// File: rtl/gmii_fcs_checker.sv
// GMII RX FCS stage: delays the byte stream, withholds the trailing FCS, checks CRC-32 and length.
// Optional statistics counters are built when GMII_FCS_STATS_EN is defined.
module gmii_fcs_checker #(
  parameter int FCS_BYTES      = 4,
  parameter int STRIP_PREAMBLE = 1,
  parameter int MIN_LEN        = 64,
  parameter int MAX_LEN        = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_dv_i,
  input  logic        gmii_er_i,
  input  logic [7:0]  gmii_data_i,
  output logic        gmii_en_o,
  output logic        gmii_er_o,
  output logic [7:0]  gmii_data_o,
  output logic        frame_done_o,
  output logic        crc_err_o,
  output logic        len_err_o,
  output logic        phy_err_o,
  output logic [15:0] frame_len_o,
  input  logic        stat_clr_i,
  output logic [31:0] stat_ok_o,
  output logic [31:0] stat_crc_o,
  output logic [31:0] stat_len_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_BODY, ST_DONE} state_e;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [7:0]  SFD         = 8'hD5;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  state_e      state_q;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic        phy_q;
  logic        len_bad;

  logic [FCS_BYTES-1:0] stg_dv_q, stg_er_q, stg_ps_q;
  logic [7:0]           stg_data_q [FCS_BYTES];
  logic                 pre_ok;

  logic        en_q, er_q;
  logic [7:0]  data_q;
  logic        frame_done_q, crc_err_q, len_err_q, phy_err_q;
  logic [15:0] frame_len_q;

  assign crc_d   = crc_byte(crc_q, gmii_data_i);
  assign len_d   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
  assign len_bad = (32'(len_q) < MIN_LEN) || (32'(len_q) > MAX_LEN);
  assign pre_ok  = (STRIP_PREAMBLE != 0) ? stg_ps_q[FCS_BYTES-1] : 1'b1;

  // A byte is only enabled once FCS_BYTES further valid bytes have followed it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_dv_q <= '0;
      stg_er_q <= '0;
      stg_ps_q <= '0;
      for (int i = 0; i < FCS_BYTES; i++) stg_data_q[i] <= 8'd0;
      en_q   <= 1'b0;
      er_q   <= 1'b0;
      data_q <= 8'd0;
    end else begin
      stg_dv_q[0]   <= gmii_dv_i;
      stg_er_q[0]   <= gmii_er_i;
      stg_ps_q[0]   <= (state_q == ST_BODY);
      stg_data_q[0] <= gmii_data_i;
      for (int i = 1; i < FCS_BYTES; i++) begin
        stg_dv_q[i]   <= stg_dv_q[i-1];
        stg_er_q[i]   <= stg_er_q[i-1];
        stg_ps_q[i]   <= stg_ps_q[i-1];
        stg_data_q[i] <= stg_data_q[i-1];
      end
      en_q   <= gmii_dv_i & (&stg_dv_q) & pre_ok;
      er_q   <= stg_er_q[FCS_BYTES-1];
      data_q <= stg_data_q[FCS_BYTES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      crc_q        <= CRC_INIT;
      len_q        <= 16'd0;
      phy_q        <= 1'b0;
      frame_done_q <= 1'b0;
      crc_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      phy_err_q    <= 1'b0;
      frame_len_q  <= 16'd0;
    end else begin
      frame_done_q <= 1'b0;
      crc_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      phy_err_q    <= 1'b0;
      frame_len_q  <= 16'd0;
      case (state_q)
        ST_IDLE: begin
          if (gmii_dv_i) begin
            state_q <= ST_PRE;
            phy_q   <= 1'b0;
          end
        end
        ST_PRE: begin
          crc_q <= CRC_INIT;
          len_q <= 16'd0;
          if (gmii_er_i) phy_q <= 1'b1;
          if (!gmii_dv_i)              state_q <= ST_IDLE;
          else if (gmii_data_i == SFD) state_q <= ST_BODY;
        end
        ST_BODY: begin
          if (gmii_dv_i) begin
            crc_q <= crc_d;
            len_q <= len_d;
            if (gmii_er_i) phy_q <= 1'b1;
          end else begin
            // Status is registered so it lines up exactly with the DONE cycle.
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
            crc_err_q    <= (FCS_BYTES == 4) && (crc_q != CRC_RESIDUE);
            len_err_q    <= len_bad;
            phy_err_q    <= phy_q;
            frame_len_q  <= len_q;
          end
        end
        ST_DONE: begin
          if (gmii_dv_i) begin
            state_q <= ST_PRE;
            phy_q   <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gmii_en_o    = en_q;
  assign gmii_er_o    = er_q;
  assign gmii_data_o  = data_q;
  assign frame_done_o = frame_done_q;
  assign crc_err_o    = crc_err_q;
  assign len_err_o    = len_err_q;
  assign phy_err_o    = phy_err_q;
  assign frame_len_o  = frame_len_q;

`ifdef GMII_FCS_STATS_EN
  logic [31:0] stat_ok_q, stat_crc_q, stat_len_q;
  logic        frame_ok;

  assign frame_ok = !(crc_err_q | len_err_q | phy_err_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok_q  <= 32'd0;
      stat_crc_q <= 32'd0;
      stat_len_q <= 32'd0;
    end else if (stat_clr_i) begin
      stat_ok_q  <= 32'd0;
      stat_crc_q <= 32'd0;
      stat_len_q <= 32'd0;
    end else if (frame_done_q) begin
      if (frame_ok && stat_ok_q != 32'hFFFFFFFF)   stat_ok_q  <= stat_ok_q + 32'd1;
      if (crc_err_q && stat_crc_q != 32'hFFFFFFFF) stat_crc_q <= stat_crc_q + 32'd1;
      if (len_err_q && stat_len_q != 32'hFFFFFFFF) stat_len_q <= stat_len_q + 32'd1;
    end
  end

  assign stat_ok_o  = stat_ok_q;
  assign stat_crc_o = stat_crc_q;
  assign stat_len_o = stat_len_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stat_ok_o  = 32'd0;
  assign stat_crc_o = 32'd0;
  assign stat_len_o = 32'd0;
`endif

endmodule

// File: tb/tb_gmii_fcs_checker.sv
// Directed bench for gmii_fcs_checker: builds Ethernet frames with an appended FCS and
// checks forwarded payload, enable bursts and end-of-frame status.
module tb_gmii_fcs_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gmii_dv_i = 1'b0;
  logic        gmii_er_i = 1'b0;
  logic [7:0]  gmii_data_i = 8'd0;
  logic        stat_clr_i = 1'b0;
  logic        gmii_en_o, gmii_er_o, frame_done_o, crc_err_o, len_err_o, phy_err_o;
  logic [7:0]  gmii_data_o;
  logic [15:0] frame_len_o;
  logic [31:0] stat_ok_o, stat_crc_o, stat_len_o;

  gmii_fcs_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gmii_dv_i    (gmii_dv_i),
    .gmii_er_i    (gmii_er_i),
    .gmii_data_i  (gmii_data_i),
    .gmii_en_o    (gmii_en_o),
    .gmii_er_o    (gmii_er_o),
    .gmii_data_o  (gmii_data_o),
    .frame_done_o (frame_done_o),
    .crc_err_o    (crc_err_o),
    .len_err_o    (len_err_o),
    .phy_err_o    (phy_err_o),
    .frame_len_o  (frame_len_o),
    .stat_clr_i   (stat_clr_i),
    .stat_ok_o    (stat_ok_o),
    .stat_crc_o   (stat_crc_o),
    .stat_len_o   (stat_len_o)
  );

  always #4 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [2:0]  st_flags_q[$];
  logic [15:0] st_len_q[$];
  int          st_gap_q[$];
  int          bursts, er_beats, stray, cyc, last_en_cyc;
  logic        prev_en = 1'b0;

  initial begin
    bursts = 0; er_beats = 0; stray = 0; cyc = 0; last_en_cyc = 0;
  end

  // Scoreboard capture of everything the DUT emits.
  always @(negedge clk) begin
    cyc++;
    if (gmii_en_o) begin
      got_q.push_back(gmii_data_o);
      if (gmii_er_o) er_beats++;
      if (!prev_en) bursts++;
      last_en_cyc = cyc;
    end
    prev_en = gmii_en_o;
    if (frame_done_o) begin
      st_flags_q.push_back({crc_err_o, len_err_o, phy_err_o});
      st_len_q.push_back(frame_len_o);
      st_gap_q.push_back(cyc - last_en_cyc);
    end else if (crc_err_o || len_err_o || phy_err_o || frame_len_o != 16'd0) begin
      stray++;
    end
  end

  task automatic clear_mon();
    got_q.delete(); exp_q.delete();
    st_flags_q.delete(); st_len_q.delete(); st_gap_q.delete();
    bursts = 0; er_beats = 0; stray = 0;
  endtask

  // Payload pattern followed by the standard Ethernet FCS (complemented CRC, LSB byte first).
  task automatic build_frame(input int n_payload, input int seed);
    logic [31:0] c;
    tx_q.delete();
    for (int i = 0; i < n_payload; i++) tx_q.push_back(8'((i * 29 + seed * 13 + 7) & 255));
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_payload; i++) begin
      c = c ^ {24'd0, tx_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) tx_q.push_back(c[8*k +: 8]);
  endtask

  task automatic load_exp();
    for (int i = 0; i < tx_q.size() - 4; i++) exp_q.push_back(tx_q[i]);
  endtask

  function automatic int payload_diffs();
    int d = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic put_byte(input logic [7:0] b, input logic e);
    @(posedge clk); #1;
    gmii_dv_i = 1'b1; gmii_data_i = b; gmii_er_i = e;
  endtask

  // er_at / abort_at index post-SFD bytes; -1 disables them.
  task automatic drive_frame(input int n_pre, input bit sfd, input int er_at, input int abort_at);
    for (int i = 0; i < n_pre; i++) put_byte(8'h55, 1'b0);
    if (sfd) begin
      put_byte(8'hD5, 1'b0);
      for (int i = 0; i < tx_q.size(); i++) begin
        if (i == abort_at) begin
          @(posedge clk); #1;
          rst_n = 1'b0; gmii_dv_i = 1'b0; gmii_er_i = 1'b0; gmii_data_i = 8'd0;
          return;
        end
        put_byte(tx_q[i], i == er_at);
      end
    end
    @(posedge clk); #1;
    gmii_dv_i = 1'b0; gmii_er_i = 1'b0; gmii_data_i = 8'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({gmii_en_o, gmii_er_o, gmii_data_o, frame_done_o, crc_err_o, len_err_o, phy_err_o, frame_len_o} !== 31'd0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0", {gmii_en_o, gmii_er_o, gmii_data_o, frame_done_o, crc_err_o, len_err_o, phy_err_o, frame_len_o});
    end
    n_vec++;
    if ({stat_ok_o, stat_crc_o, stat_len_o} !== 96'd0) begin
      n_err++; $display("FAIL reset_stats got %h %h %h want 0", stat_ok_o, stat_crc_o, stat_len_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_good_frame();
    clear_mon();
    build_frame(60, 1); load_exp();
    drive_frame(7, 1'b1, -1, -1);
    repeat (12) @(posedge clk);
    n_vec++; if (got_q.size() !== 60) begin n_err++; $display("FAIL good_count got %0d want 60", got_q.size()); end
    n_vec++; if (payload_diffs() !== 0) begin n_err++; $display("FAIL good_payload got %0d bad bytes want 0", payload_diffs()); end
    n_vec++; if (st_flags_q.size() !== 1) begin n_err++; $display("FAIL good_strobes got %0d want 1", st_flags_q.size()); end
    n_vec++; if (st_flags_q[0] !== 3'b000) begin n_err++; $display("FAIL good_flags got %b want 000", st_flags_q[0]); end
    n_vec++; if (st_len_q[0] !== 16'd64) begin n_err++; $display("FAIL good_len got %0d want 64", st_len_q[0]); end
    n_vec++; if (st_gap_q[0] !== 1) begin n_err++; $display("FAIL good_strobe_timing got %0d want 1", st_gap_q[0]); end
    n_vec++; if (bursts !== 1 || stray !== 0) begin n_err++; $display("FAIL good_bursts got %0d/%0d want 1/0", bursts, stray); end
  endtask

  task automatic test_crc_error();
    clear_mon();
    build_frame(60, 2);
    tx_q[10] = tx_q[10] ^ 8'h08;
    load_exp();
    drive_frame(7, 1'b1, -1, -1);
    repeat (12) @(posedge clk);
    n_vec++; if (got_q.size() !== 60) begin n_err++; $display("FAIL crc_count got %0d want 60", got_q.size()); end
    n_vec++; if (payload_diffs() !== 0) begin n_err++; $display("FAIL crc_payload got %0d bad bytes want 0", payload_diffs()); end
    n_vec++; if (st_flags_q.size() !== 1) begin n_err++; $display("FAIL crc_strobes got %0d want 1", st_flags_q.size()); end
    n_vec++; if (st_flags_q[0] !== 3'b100) begin n_err++; $display("FAIL crc_flags got %b want 100", st_flags_q[0]); end
    n_vec++; if (st_len_q[0] !== 16'd64) begin n_err++; $display("FAIL crc_len got %0d want 64", st_len_q[0]); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    build_frame(60, 3); load_exp();
    drive_frame(7, 1'b1, -1, -1);
    build_frame(60, 4); load_exp();
    drive_frame(7, 1'b1, -1, -1);
    repeat (12) @(posedge clk);
    n_vec++; if (bursts !== 2) begin n_err++; $display("FAIL b2b_bursts got %0d want 2", bursts); end
    n_vec++; if (got_q.size() !== 120) begin n_err++; $display("FAIL b2b_count got %0d want 120", got_q.size()); end
    n_vec++; if (payload_diffs() !== 0) begin n_err++; $display("FAIL b2b_payload got %0d bad bytes want 0", payload_diffs()); end
    n_vec++; if (st_flags_q.size() !== 2) begin n_err++; $display("FAIL b2b_strobes got %0d want 2", st_flags_q.size()); end
    n_vec++; if ({st_flags_q[0], st_flags_q[1]} !== 6'b0) begin n_err++; $display("FAIL b2b_flags got %b %b want 000 000", st_flags_q[0], st_flags_q[1]); end
    n_vec++; if (st_gap_q[0] !== 1 || st_gap_q[1] !== 1) begin n_err++; $display("FAIL b2b_strobe_timing got %0d %0d want 1 1", st_gap_q[0], st_gap_q[1]); end
  endtask

  task automatic test_length_errors();
    clear_mon();
    build_frame(36, 5); load_exp();
    drive_frame(7, 1'b1, -1, -1);
    repeat (10) @(posedge clk);
    build_frame(1596, 6); load_exp();
    drive_frame(7, 1'b1, -1, -1);
    repeat (12) @(posedge clk);
    n_vec++; if (st_flags_q.size() !== 2) begin n_err++; $display("FAIL len_strobes got %0d want 2", st_flags_q.size()); end
    n_vec++; if (st_flags_q[0] !== 3'b010) begin n_err++; $display("FAIL short_flags got %b want 010", st_flags_q[0]); end
    n_vec++; if (st_len_q[0] !== 16'd40) begin n_err++; $display("FAIL short_len got %0d want 40", st_len_q[0]); end
    n_vec++; if (st_flags_q[1] !== 3'b010) begin n_err++; $display("FAIL long_flags got %b want 010", st_flags_q[1]); end
    n_vec++; if (st_len_q[1] !== 16'd1600) begin n_err++; $display("FAIL long_len got %0d want 1600", st_len_q[1]); end
    n_vec++; if (got_q.size() !== 1632) begin n_err++; $display("FAIL len_count got %0d want 1632", got_q.size()); end
    n_vec++; if (payload_diffs() !== 0) begin n_err++; $display("FAIL len_payload got %0d bad bytes want 0", payload_diffs()); end
  endtask

  task automatic test_phy_error();
    clear_mon();
    build_frame(60, 7); load_exp();
    drive_frame(7, 1'b1, 20, -1);
    repeat (12) @(posedge clk);
    n_vec++; if (st_flags_q.size() !== 1) begin n_err++; $display("FAIL phy_strobes got %0d want 1", st_flags_q.size()); end
    n_vec++; if (st_flags_q[0] !== 3'b001) begin n_err++; $display("FAIL phy_flags got %b want 001", st_flags_q[0]); end
    n_vec++; if (er_beats !== 1) begin n_err++; $display("FAIL phy_er_out got %0d want 1", er_beats); end
    clear_mon();
    drive_frame(10, 1'b0, -1, -1);
    repeat (12) @(posedge clk);
    n_vec++; if (st_flags_q.size() !== 0) begin n_err++; $display("FAIL nosfd_strobes got %0d want 0", st_flags_q.size()); end
    n_vec++; if (got_q.size() !== 0) begin n_err++; $display("FAIL nosfd_enables got %0d want 0", got_q.size()); end
  endtask

  task automatic test_reset_abort();
    clear_mon();
    build_frame(60, 8);
    drive_frame(7, 1'b1, -1, 30);
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if ({gmii_en_o, gmii_er_o, gmii_data_o, frame_done_o, crc_err_o, len_err_o, phy_err_o, frame_len_o} !== 31'd0) begin
        n_err++; $display("FAIL abort_outputs got %h want 0", {gmii_en_o, gmii_er_o, gmii_data_o, frame_done_o, crc_err_o, len_err_o, phy_err_o, frame_len_o});
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    got_q.delete(); exp_q.delete();
    build_frame(60, 9); load_exp();
    drive_frame(7, 1'b1, -1, -1);
    repeat (12) @(posedge clk);
    n_vec++; if (st_flags_q.size() !== 1) begin n_err++; $display("FAIL abort_strobes got %0d want 1", st_flags_q.size()); end
    n_vec++; if (st_flags_q[0] !== 3'b000 || st_len_q[0] !== 16'd64) begin n_err++; $display("FAIL abort_next_status got %b/%0d want 000/64", st_flags_q[0], st_len_q[0]); end
    n_vec++; if (got_q.size() !== 60 || payload_diffs() !== 0) begin n_err++; $display("FAIL abort_next_payload got %0d bytes %0d bad want 60 0", got_q.size(), payload_diffs()); end
    @(negedge clk);
`ifdef GMII_FCS_STATS_EN
    n_vec++; if ({stat_ok_o, stat_crc_o, stat_len_o} !== {32'd1, 32'd0, 32'd0}) begin n_err++; $display("FAIL stats got %0d %0d %0d want 1 0 0", stat_ok_o, stat_crc_o, stat_len_o); end
    @(posedge clk); #1 stat_clr_i = 1'b1;
    @(posedge clk); #1 stat_clr_i = 1'b0;
    @(negedge clk);
    n_vec++; if (stat_ok_o !== 32'd0) begin n_err++; $display("FAIL stats_clr got %0d want 0", stat_ok_o); end
`else
    n_vec++; if ({stat_ok_o, stat_crc_o, stat_len_o} !== 96'd0) begin n_err++; $display("FAIL stats_off got %0d %0d %0d want 0", stat_ok_o, stat_crc_o, stat_len_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_back_to_back();
    test_length_errors();
    test_phy_error();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
